// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered N-to-2**N one-hot decoder with direct and timed scan modes
// Either holds a loaded select or walks the active output through every position, HOLD cycles each.
module decoder_scan #(
  parameter int N    = 3,
  parameter int HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      sel,
  output logic [(1<<N)-1:0] y,
  output logic [N-1:0]      idx,
  output logic              wrap
);

  localparam int OUTS = 1 << N;
  localparam int HW   = (HOLD > 1) ? $clog2(HOLD) : 1;

  localparam logic [HW-1:0]   HCNT_LAST = HW'(HOLD - 1);
  localparam logic [N-1:0]    IDX_LAST  = N'(OUTS - 1);
  localparam logic [OUTS-1:0] ONE_HOT0  = OUTS'(1);

  logic [N-1:0]    idx_q, idx_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [OUTS-1:0] y_q, y_d;
  logic            wrap_q, wrap_d;

  always_comb begin
    idx_d  = idx_q;
    hcnt_d = hcnt_q;
    wrap_d = 1'b0;
    y_d    = '0;
    if (en) begin
      if (load) begin
        // A load wins over a hold expiry, so no step or wrap is taken on that edge.
        idx_d  = sel;
        hcnt_d = '0;
      end else if (!mode) begin
        hcnt_d = '0;
      end else if (hcnt_q == HCNT_LAST) begin
        hcnt_d = '0;
        idx_d  = idx_q + 1'b1;
        wrap_d = (idx_q == IDX_LAST);
      end else begin
        hcnt_d = hcnt_q + 1'b1;
      end
      // Decode the index being written this edge so y has no extra cycle of lag.
      y_d = ONE_HOT0 << idx_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= '0;
      hcnt_q <= '0;
      y_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      hcnt_q <= hcnt_d;
      y_q    <= y_d;
      wrap_q <= wrap_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - directed vector bench for decoder_scan with N=3, HOLD=4
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       rst, en, mode, load;
  logic [2:0] sel;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;

  int n_vec = 0;
  int n_err = 0;

  decoder_scan #(.N(3), .HOLD(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load),
    .sel(sel), .y(y), .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, en, mode, load;
    logic [2:0] sel;
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
  } vec_t;

  localparam int NV = 47;
  vec_t vecs[NV];

  function automatic vec_t mk(logic r, logic e, logic m, logic l, logic [2:0] s,
                              logic [7:0] ey, logic [2:0] ei, logic ew);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.load = l; v.sel = s;
    v.y = ey; v.idx = ei; v.wrap = ew;
    return v;
  endfunction

  task automatic apply(input logic r, input logic e, input logic m, input logic l,
                       input logic [2:0] s);
    @(negedge clk);
    rst = r; en = e; mode = m; load = l; sel = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] ey, input logic [2:0] ei,
                       input logic ew);
    n_vec++;
    if ({y, idx, wrap} !== {ey, ei, ew}) begin
      n_err++;
      $display("FAIL %s: got y=%b idx=%0d wrap=%b, want y=%b idx=%0d wrap=%b",
               name, y, idx, wrap, ey, ei, ew);
    end
  endtask

  initial begin
    int wraps;
    int exp_idx;
    rst = 1'b1; en = 1'b1; mode = 1'b0; load = 1'b0; sel = 3'd0;

    //            rst en md ld sel    y         idx wrap
    vecs[0]  = mk(1, 1, 0, 0, 3'd0, 8'h00, 3'd0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 3'd0, 8'h00, 3'd0, 0);
    vecs[2]  = mk(0, 1, 0, 0, 3'd0, 8'h01, 3'd0, 0);
    vecs[3]  = mk(0, 1, 0, 1, 3'd5, 8'h20, 3'd5, 0);
    vecs[4]  = mk(0, 1, 0, 0, 3'd0, 8'h20, 3'd5, 0);
    vecs[5]  = mk(0, 0, 0, 0, 3'd0, 8'h00, 3'd5, 0);
    vecs[6]  = mk(0, 0, 0, 1, 3'd2, 8'h00, 3'd5, 0);
    vecs[7]  = mk(0, 1, 0, 0, 3'd0, 8'h20, 3'd5, 0);
    // scan: load 4, then load 6 on the hold-expiry edge
    vecs[8]  = mk(0, 1, 1, 1, 3'd4, 8'h10, 3'd4, 0);
    vecs[9]  = mk(0, 1, 1, 0, 3'd0, 8'h10, 3'd4, 0);
    vecs[10] = mk(0, 1, 1, 0, 3'd0, 8'h10, 3'd4, 0);
    vecs[11] = mk(0, 1, 1, 0, 3'd0, 8'h10, 3'd4, 0);
    vecs[12] = mk(0, 1, 1, 1, 3'd6, 8'h40, 3'd6, 0);
    vecs[13] = mk(0, 1, 1, 0, 3'd0, 8'h40, 3'd6, 0);
    vecs[14] = mk(0, 1, 1, 0, 3'd0, 8'h40, 3'd6, 0);
    vecs[15] = mk(0, 1, 1, 0, 3'd0, 8'h40, 3'd6, 0);
    vecs[16] = mk(0, 1, 1, 0, 3'd0, 8'h80, 3'd7, 0);
    vecs[17] = mk(0, 1, 1, 0, 3'd0, 8'h80, 3'd7, 0);
    vecs[18] = mk(0, 1, 1, 0, 3'd0, 8'h80, 3'd7, 0);
    vecs[19] = mk(0, 1, 1, 0, 3'd0, 8'h80, 3'd7, 0);
    vecs[20] = mk(0, 1, 1, 0, 3'd0, 8'h01, 3'd0, 1);
    vecs[21] = mk(0, 1, 1, 0, 3'd0, 8'h01, 3'd0, 0);
    // direct for one edge clears hcnt; scan restarts a full hold
    vecs[22] = mk(0, 1, 0, 0, 3'd0, 8'h01, 3'd0, 0);
    vecs[23] = mk(0, 1, 1, 0, 3'd0, 8'h01, 3'd0, 0);
    vecs[24] = mk(0, 1, 1, 0, 3'd0, 8'h01, 3'd0, 0);
    vecs[25] = mk(0, 1, 1, 0, 3'd0, 8'h01, 3'd0, 0);
    vecs[26] = mk(0, 1, 1, 0, 3'd0, 8'h02, 3'd1, 0);
    vecs[27] = mk(0, 1, 1, 0, 3'd0, 8'h02, 3'd1, 0);
    vecs[28] = mk(0, 1, 1, 0, 3'd0, 8'h02, 3'd1, 0);
    vecs[29] = mk(0, 1, 1, 0, 3'd0, 8'h02, 3'd1, 0);
    vecs[30] = mk(0, 1, 1, 0, 3'd0, 8'h04, 3'd2, 0);
    vecs[31] = mk(0, 1, 1, 0, 3'd0, 8'h04, 3'd2, 0);
    vecs[32] = mk(0, 1, 1, 0, 3'd0, 8'h04, 3'd2, 0);
    // pause with hcnt=2, then resume mid-hold
    vecs[33] = mk(0, 0, 1, 0, 3'd0, 8'h00, 3'd2, 0);
    vecs[34] = mk(0, 0, 1, 0, 3'd0, 8'h00, 3'd2, 0);
    vecs[35] = mk(0, 0, 1, 0, 3'd0, 8'h00, 3'd2, 0);
    vecs[36] = mk(0, 0, 1, 0, 3'd0, 8'h00, 3'd2, 0);
    vecs[37] = mk(0, 0, 1, 0, 3'd0, 8'h00, 3'd2, 0);
    vecs[38] = mk(0, 1, 1, 0, 3'd0, 8'h04, 3'd2, 0);
    vecs[39] = mk(0, 1, 1, 0, 3'd0, 8'h08, 3'd3, 0);
    // reset mid-scan at idx 6
    vecs[40] = mk(0, 1, 1, 1, 3'd6, 8'h40, 3'd6, 0);
    vecs[41] = mk(0, 1, 1, 0, 3'd0, 8'h40, 3'd6, 0);
    vecs[42] = mk(1, 1, 1, 0, 3'd0, 8'h00, 3'd0, 0);
    vecs[43] = mk(0, 1, 1, 0, 3'd0, 8'h01, 3'd0, 0);
    vecs[44] = mk(0, 1, 1, 0, 3'd0, 8'h01, 3'd0, 0);
    vecs[45] = mk(0, 1, 1, 0, 3'd0, 8'h01, 3'd0, 0);
    vecs[46] = mk(0, 1, 1, 0, 3'd0, 8'h02, 3'd1, 0);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].load, vecs[i].sel);
      check($sformatf("vec%0d", i), vecs[i].y, vecs[i].idx, vecs[i].wrap);
    end

    // Two full scan periods from a fresh reset: step every 4th edge, wrap every 32nd.
    apply(1, 1, 1, 0, 3'd0);
    check("scan_rst", 8'h00, 3'd0, 1'b0);
    wraps = 0;
    for (int k = 1; k <= 64; k++) begin
      apply(0, 1, 1, 0, 3'd0);
      exp_idx = (k / 4) % 8;
      if (wrap) wraps++;
      check($sformatf("scan_k%0d", k), 8'(1 << exp_idx), 3'(exp_idx), (k % 32) == 0);
    end
    n_vec++;
    if (wraps != 2) begin
      n_err++;
      $display("FAIL scan_wrap_count: got %0d, want 2", wraps);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
